// File: rtl/rw_pkg.sv
// ---------------------------------------------------------------------------
// rw_pkg
// Shared definitions for the auxiliary-memory bus sequencer and the DRAM
// controller that decodes its phase output.
//   phase_t      : 4-bit bus-cycle phase (0 = idle, 1..15 = phase)
//   PH_*         : phases at which the sequencer samples or acts
//   CYC_*        : PHI1 cycle lengths in C14M periods used for lock tracking
//   sat_inc5()   : saturating increment for the 5-bit interval counter
// ---------------------------------------------------------------------------
package rw_pkg;

    typedef logic [3:0] phase_t;

    localparam phase_t PH_IDLE  = 4'd0;
    localparam phase_t PH_START = 4'd1;
    localparam phase_t PH_ADDR  = 4'd2;
    localparam phase_t PH_DEV   = 4'd5;
    localparam phase_t PH_DATA  = 4'd6;
    localparam phase_t PH_SAT   = 4'd15;

    localparam logic [4:0] CYC_SHORT   = 5'd14;
    localparam logic [4:0] CYC_LONG    = 5'd16;
    localparam logic [4:0] CYC_TIMEOUT = 5'd21;
    localparam logic [4:0] CYC_MAX     = 5'd31;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == CYC_MAX) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/phi1_qualifier.sv
// ---------------------------------------------------------------------------
// phi1_qualifier
// Synchronizes PHI1 into the C14M domain, qualifies its rising edge and
// tracks whether the PHI1 period is a legal 14 or 16 C14M cycle.
//   clk_i    : C14M, all logic on posedge
//   rst_ni   : asynchronous active-low reset
//   phi1_i   : raw PHI1, asynchronous
//   rise_o   : combinational, high for one C14M when a qualified rise is seen
//   locked_o : two consecutive legal periods observed and no timeout since
// ---------------------------------------------------------------------------
module phi1_qualifier
    import rw_pkg::*;
#(
    parameter int SYNC_LEN = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic phi1_i,
    output logic rise_o,
    output logic locked_o
);

    localparam int            LW       = $clog2(SYNC_LEN + 1);
    localparam logic [LW-1:0] LOW_FULL = LW'(SYNC_LEN);

    logic          p1_meta_q;
    logic          p1s_q;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [4:0]    interval_q, interval_d;
    logic [1:0]    good_q, good_d;

    always_comb begin
        // A rise only counts after a full run of low samples; this rejects
        // short high glitches early in the low phase.
        rise_o = p1s_q && (low_cnt_q == LOW_FULL);

        low_cnt_d = low_cnt_q;
        if (p1s_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_FULL) begin
            low_cnt_d = low_cnt_q + LW'(1);
        end

        interval_d = rise_o ? 5'd1 : sat_inc5(interval_q);

        // interval_q holds the length of the period that just ended.
        good_d = good_q;
        if (rise_o) begin
            if (interval_q == CYC_SHORT || interval_q == CYC_LONG) begin
                good_d = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
            end else begin
                good_d = 2'd0;
            end
        end else if (interval_q == CYC_TIMEOUT) begin
            good_d = 2'd0;
        end
    end

    assign locked_o = (good_q == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p1_meta_q  <= 1'b0;
            p1s_q      <= 1'b0;
            low_cnt_q  <= '0;
            interval_q <= '0;
            good_q     <= '0;
        end else begin
            p1_meta_q  <= phi1_i;
            p1s_q      <= p1_meta_q;
            low_cnt_q  <= low_cnt_d;
            interval_q <= interval_d;
            good_q     <= good_d;
        end
    end

endmodule

// File: rtl/rw_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rw_bus_sequencer
// Front end of the auxiliary-memory DRAM controller. Generates the bus-cycle
// phase S from qualified PHI1 rises, flags aux writes, captures RAMWorks
// bank-register writes and schedules refresh cycles.
//   C14M        : master clock, all logic on posedge
//   nRES        : asynchronous active-low reset
//   PHI1        : Apple II PHI1, asynchronous
//   RnW, nEN80, nC07X, RA, MD : 6502 bus inputs (RA[3], RA[0] used)
//   S           : bus-cycle phase, saturates at 15
//   CycleStart  : one-C14M pulse coincident with S becoming 1
//   CPUWr       : aux write in current cycle
//   Bank        : RAMWorks bank register
//   BankWrP     : one-C14M pulse when Bank is loaded
//   RefReq      : refresh this bus cycle
//   Locked      : PHI1 timing qualified
// ---------------------------------------------------------------------------
module rw_bus_sequencer
    import rw_pkg::*;
#(
    parameter int SYNC_LEN = 6,
    parameter int REF_DIV  = 7,
    parameter int BANK_W   = 8
) (
    input  logic              C14M,
    input  logic              nRES,
    input  logic              PHI1,
    input  logic              RnW,
    input  logic              nEN80,
    input  logic              nC07X,
    input  logic [7:0]        RA,
    input  logic [7:0]        MD,
    output phase_t            S,
    output logic              CycleStart,
    output logic              CPUWr,
    output logic [BANK_W-1:0] Bank,
    output logic              BankWrP,
    output logic              RefReq,
    output logic              Locked
);

    localparam logic [3:0] REF_LAST = 4'(REF_DIV - 1);

    logic              rise;
    logic              locked;
    phase_t            s_q, s_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              cand_q, cand_d;
    logic              bwp_q, bwp_d;
    logic              ref_q, ref_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [3:0]        refc_q, refc_d;

    logic unused_ra;
    logic unused_md;
    assign unused_ra = ^{RA[7:4], RA[2:1]};
    assign unused_md = ^MD;

    phi1_qualifier #(
        .SYNC_LEN (SYNC_LEN)
    ) u_qual (
        .clk_i    (C14M),
        .rst_ni   (nRES),
        .phi1_i   (PHI1),
        .rise_o   (rise),
        .locked_o (locked)
    );

    always_comb begin
        s_d    = s_q;
        cs_d   = 1'b0;
        wr_d   = wr_q;
        cand_d = cand_q;
        bwp_d  = 1'b0;
        bank_d = bank_q;
        refc_d = refc_q;
        ref_d  = ref_q;

        // Rise pre-empts every phase-qualified action on the same edge.
        if (rise) begin
            s_d    = PH_START;
            cs_d   = 1'b1;
            wr_d   = 1'b0;
            cand_d = 1'b0;
            // refc_q counts the Rises before this one, so every REF_DIV-th
            // Rise opens a refresh cycle; RefReq then holds until next Rise.
            ref_d  = (refc_q == REF_LAST);
            refc_d = (refc_q == REF_LAST) ? 4'd0 : refc_q + 4'd1;
        end else begin
            if (s_q != PH_IDLE && s_q != PH_SAT) begin
                s_d = s_q + 4'd1;
            end
            case (s_q)
                PH_ADDR: begin
                    wr_d   = !RnW && !nEN80;
                    cand_d = !RnW && !RA[3] && RA[0];
                end
                PH_DEV: begin
                    cand_d = cand_q && !nC07X;
                end
                PH_DATA: begin
                    if (cand_q && locked) begin
                        bank_d = MD[BANK_W-1:0];
                        bwp_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge C14M or negedge nRES) begin
        if (!nRES) begin
            s_q    <= PH_IDLE;
            cs_q   <= 1'b0;
            wr_q   <= 1'b0;
            cand_q <= 1'b0;
            bwp_q  <= 1'b0;
            ref_q  <= 1'b0;
            bank_q <= '0;
            refc_q <= '0;
        end else begin
            s_q    <= s_d;
            cs_q   <= cs_d;
            wr_q   <= wr_d;
            cand_q <= cand_d;
            bwp_q  <= bwp_d;
            ref_q  <= ref_d;
            bank_q <= bank_d;
            refc_q <= refc_d;
        end
    end

    assign S          = s_q;
    assign CycleStart = cs_q;
    assign CPUWr      = wr_q;
    assign Bank       = bank_q;
    assign BankWrP    = bwp_q;
    assign RefReq     = ref_q;
    assign Locked     = locked;

endmodule

// File: tb/tb_rw_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rw_bus_sequencer
// Directed PHI1/bus stimulus; expected per-cycle responses are queued when a
// bus cycle is issued and popped by a monitor on CycleStart, at S==3 (CPUWr)
// and on BankWrP.
// ---------------------------------------------------------------------------
module tb_rw_bus_sequencer;

    localparam int REF_DIV = 7;

    logic       C14M  = 1'b0;
    logic       nRES  = 1'b0;
    logic       PHI1  = 1'b0;
    logic       RnW   = 1'b1;
    logic       nEN80 = 1'b1;
    logic       nC07X = 1'b1;
    logic [7:0] RA    = 8'h00;
    logic [7:0] MD    = 8'h00;
    logic [3:0] S;
    logic       CycleStart, CPUWr, BankWrP, RefReq, Locked;
    logic [7:0] Bank;

    int n_tests = 0;
    int n_fail  = 0;

    rw_bus_sequencer #(
        .SYNC_LEN (6),
        .REF_DIV  (REF_DIV),
        .BANK_W   (8)
    ) dut (
        .C14M       (C14M),
        .nRES       (nRES),
        .PHI1       (PHI1),
        .RnW        (RnW),
        .nEN80      (nEN80),
        .nC07X      (nC07X),
        .RA         (RA),
        .MD         (MD),
        .S          (S),
        .CycleStart (CycleStart),
        .CPUWr      (CPUWr),
        .Bank       (Bank),
        .BankWrP    (BankWrP),
        .RefReq     (RefReq),
        .Locked     (Locked)
    );

    always #35 C14M = ~C14M;

    typedef struct packed {
        logic       locked;
        logic       refreq;
        logic [3:0] prev_s;
    } cyc_exp_t;

    cyc_exp_t   cyc_q[$];
    logic       wr_q[$];
    logic [7:0] bank_q[$];

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    cyc_exp_t   mon_e;
    logic       mon_w;
    logic [7:0] mon_b;
    logic [3:0] last_s = 4'd0;

    always @(negedge C14M) begin
        if (CycleStart) begin
            if (cyc_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cycle_start: unexpected CycleStart with S=%0d, none required", S);
            end else begin
                mon_e = cyc_q.pop_front();
                chk_v("S_at_start", 8'(S), 8'd1);
                chk_b("Locked_at_start", Locked, mon_e.locked);
                chk_b("RefReq_at_start", RefReq, mon_e.refreq);
                chk_v("S_before_rise", 8'(last_s), 8'(mon_e.prev_s));
            end
        end
        if (S == 4'd3) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cpuwr: S=3 reached with no cycle issued, CPUWr=%0b", CPUWr);
            end else begin
                mon_w = wr_q.pop_front();
                chk_b("CPUWr", CPUWr, mon_w);
            end
        end
        if (BankWrP) begin
            if (bank_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bank_wr: unexpected BankWrP with Bank=0x%0h, none required", Bank);
            end else begin
                mon_b = bank_q.pop_front();
                chk_v("Bank_on_write", Bank, mon_b);
            end
        end
        last_s = S;
    end

    // ---------------- reference model state ----------------
    int         rises       = 0;
    int         good        = 0;
    int         prev_period = 0;
    int         prev_s      = 0;
    logic       last_ref    = 1'b0;
    logic [7:0] bank_m      = 8'h00;

    task automatic seg(input logic lvl, input int n);
        PHI1 = lvl;
        repeat (n) @(negedge C14M);
    endtask

    task automatic note_rise(input logic cand, input logic wr, input logic [7:0] md,
                             input logic allow_bank);
        cyc_exp_t e;
        rises++;
        if (rises == 1)                               good = 0;
        else if (prev_period == 14 || prev_period == 16) good = (good == 2) ? 2 : good + 1;
        else                                          good = 0;
        e.locked = (good == 2);
        e.refreq = ((rises % REF_DIV) == 0);
        e.prev_s = 4'(prev_s);
        last_ref = e.refreq;
        cyc_q.push_back(e);
        wr_q.push_back(wr);
        if (allow_bank && cand && good == 2) begin
            bank_m = md;
            bank_q.push_back(md);
        end
    endtask

    task automatic bus_cycle(input int hi, input int lo, input logic glitch,
                             input logic rnw, input logic [7:0] ra, input logic nc07x,
                             input logic nen80, input logic [7:0] md);
        int period;
        RnW   = rnw;
        RA    = ra;
        nC07X = nc07x;
        nEN80 = nen80;
        MD    = md;
        period = glitch ? 14 : hi + lo;
        note_rise(!rnw && !ra[3] && ra[0] && !nc07x, !rnw && !nen80, md, 1'b1);
        if (glitch) begin
            seg(1'b1, 5); seg(1'b0, 1); seg(1'b1, 2); seg(1'b0, 6);
        end else begin
            seg(1'b1, hi); seg(1'b0, lo);
        end
        prev_period = period;
        prev_s      = (period > 15) ? 15 : period;
    endtask

    task automatic model_reset();
        rises       = 0;
        good        = 0;
        prev_period = 0;
        prev_s      = 0;
        last_ref    = 1'b0;
        bank_m      = 8'h00;
    endtask

    task automatic do_reset();
        nRES = 1'b0;
        PHI1 = 1'b0;
        repeat (3) @(negedge C14M);
        chk_v("rst_S", 8'(S), 8'd0);
        chk_b("rst_CycleStart", CycleStart, 1'b0);
        chk_b("rst_CPUWr", CPUWr, 1'b0);
        chk_v("rst_Bank", Bank, 8'h00);
        chk_b("rst_BankWrP", BankWrP, 1'b0);
        chk_b("rst_RefReq", RefReq, 1'b0);
        chk_b("rst_Locked", Locked, 1'b0);
        nRES = 1'b1;
        model_reset();
        seg(1'b0, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Reset, then lock-up on 14-cycle PHI1 with reads.
        do_reset();
        for (int i = 0; i < 5; i++) bus_cycle(7, 7, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);

        // Locked writes: bank hit, RA[3]=1 miss, even-address miss.
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'hA5);
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 8'h3C);
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11);

        // No $C07x decode, read cycle, and a write with aux deselected.
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h66);
        bus_cycle(7, 7, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h55);
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h42);

        // Glitched cycle, long cycle, then a write that still needs lock.
        bus_cycle(7, 7, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        bus_cycle(8, 8, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'hC3);

        // PHI1 stops.
        seg(1'b0, 40);
        prev_period += 40;
        prev_s = 15;
        chk_v("stop_S", 8'(S), 8'd15);
        chk_b("stop_Locked", Locked, 1'b0);
        chk_b("stop_RefReq_hold", RefReq, last_ref);
        chk_v("stop_Bank", Bank, bank_m);

        // Unlocked write is dropped.
        bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h99);
        chk_v("unlocked_Bank", Bank, bank_m);

        // Refresh cadence from reset, with one bank write in between.
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            if (i == 10) bus_cycle(7, 7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h77);
            else         bus_cycle(7, 7, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        end
        chk_v("pre_reset_Bank", Bank, bank_m);

        // Reset in the middle of a bank-write cycle.
        RnW = 1'b0; RA = 8'h01; nC07X = 1'b0; nEN80 = 1'b0; MD = 8'h5A;
        note_rise(1'b1, 1'b1, 8'h5A, 1'b0);
        PHI1  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge C14M);
            if (S == 4'd4) found = 1'b1;
        end
        chk_b("reached_S4", found, 1'b1);
        chk_b("midrst_CPUWr_before", CPUWr, 1'b1);
        nRES = 1'b0;
        #1;
        chk_v("midrst_S", 8'(S), 8'd0);
        chk_b("midrst_CycleStart", CycleStart, 1'b0);
        chk_b("midrst_CPUWr", CPUWr, 1'b0);
        chk_v("midrst_Bank", Bank, 8'h00);
        chk_b("midrst_BankWrP", BankWrP, 1'b0);
        chk_b("midrst_RefReq", RefReq, 1'b0);
        chk_b("midrst_Locked", Locked, 1'b0);
        PHI1 = 1'b0;
        repeat (2) @(negedge C14M);
        nRES = 1'b1;
        model_reset();
        seg(1'b0, 8);
        chk_v("post_rst_Bank", Bank, 8'h00);

        bus_cycle(7, 7, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        bus_cycle(7, 7, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        seg(1'b0, 20);
        chk_v("post_rst_Bank_end", Bank, 8'h00);

        chk_v("cyc_q_drained", 8'(cyc_q.size()), 8'd0);
        chk_v("wr_q_drained", 8'(wr_q.size()), 8'd0);
        chk_v("bank_q_drained", 8'(bank_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rw_bus_sequencer.md
Name: rw_bus_sequencer

Overview:
Upstream front end of the auxiliary-memory DRAM controller. It qualifies the Apple II PHI1 clock against C14M and generates the 4-bit bus-cycle phase S that the DRAM controller decodes. It also tracks lock to the 14/16-C14M cycle, captures RAMWorks bank-register writes ($C07x, odd address, RA[3]=0) and schedules one refresh request every REF_DIV bus cycles. Outputs feed the DRAM RAS/CAS/address sequencer directly.

Parameters:
SYNC_LEN, 6, consecutive synchronized-low PHI1 samples required before a rise qualifies
REF_DIV, 7, bus cycles per refresh request (2..15)
BANK_W, 8, bank register width (1..8)

Ports:
C14M  in  1  14.318 MHz master clock; all logic on posedge
nRES  in  1  asynchronous active-low reset
PHI1  in  1  Apple II PHI1, asynchronous to logic
RnW  in  1  6502 read/not-write
nEN80  in  1  aux memory select, active low
nC07X  in  1  $C07x decode, active low
RA  in  8  multiplexed address; only RA[3] and RA[0] used
MD  in  8  6502 data bus
S  out  4  bus-cycle phase; 0 = idle, 1..15 = phase, saturates at 15
CycleStart  out  1  one-C14M pulse coincident with S becoming 1
CPUWr  out  1  aux write in current cycle
Bank  out  BANK_W  RAMWorks bank register
BankWrP  out  1  one-C14M pulse when Bank is loaded
RefReq  out  1  refresh this bus cycle
Locked  out  1  PHI1 timing qualified

Behaviour:
- Reset, asynchronous, nRES low: S=0, CycleStart=0, CPUWr=0, Bank=0, BankWrP=0, RefReq=0, Locked=0; internal counters and synchronizer cleared. Mid-cycle reset abandons the cycle. No bank write completes.
- PHI1 path: 2-flop synchronizer gives p1s. LowCnt counts consecutive p1s=0 samples and saturates at SYNC_LEN. It clears on p1s=1.
- Rise: p1s=1 while LowCnt==SYNC_LEN in the same cycle. Latency from PHI1 edge to CycleStart is 2-3 C14M.
- Phase: on Rise, S<=1 and CycleStart=1. Otherwise, if S is neither 0 nor 15, S<=S+1. S=15 holds until the next Rise.
- A Rise while S is mid-count restarts S at 1 and clears the bank-write candidate.
- Lock: Interval is a 5-bit counter, reset to 1 on Rise, saturating at 31.
  - A Rise with Interval of 14 or 16 (the value before reset) increments GoodCnt, saturating at 2.
  - Any other interval at a Rise clears GoodCnt and Locked.
  - Locked=1 when GoodCnt reaches 2.
  - Interval reaching 21 clears GoodCnt and Locked.
- CPUWr: at S==2, CPUWr <= !RnW && !nEN80. It is cleared when S becomes 1.
- Bank write:
  - At S==2: Cand <= !RnW && !RA[3] && RA[0].
  - At S==5: Cand <= Cand && !nC07X.
  - At S==6, if Cand && Locked: Bank <= MD[BANK_W-1:0] and BankWrP=1 for exactly that one cycle.
  - With Locked=0 the write is dropped.
- Refresh: RefC counts Rise events modulo REF_DIV, wrapping REF_DIV-1 to 0. RefReq = (RefC==REF_DIV-1) && S!=0. It is registered, so it is valid from the cycle S=1 onward.
  - Refresh runs regardless of Locked.
  - At S=15 saturation, RefReq holds until the next Rise.
- Simultaneous events: Rise has priority over every phase-qualified action in the same C14M edge. A rise at S==6 does not load Bank.

Decomposition:
- Shared package rw_pkg holds:
  - phase constants PH_IDLE=0, PH_START=1, PH_ADDR=2, PH_DEV=5, PH_DATA=6, PH_SAT=15
  - cycle-length constants CYC_SHORT=14, CYC_LONG=16, CYC_TIMEOUT=21
  - typedef phase_t (4-bit), used by both this block and the DRAM controller
- One sub-module, phi1_qualifier: synchronizer, LowCnt, Rise, Interval and lock logic. Outputs are Rise and Locked.

Test Plan:
1. Reset then PHI1 period 14 C14M (7 high / 7 low): Locked=0 after the first Rise and 1 after the third. S runs 1..14 and restarts at 1. CycleStart appears once per cycle.
2. Locked; write cycle: RnW=0, RA=0x01, nC07X=0 at S=5, MD=0xA5 at S=6. Response: Bank=0xA5 and a single BankWrP on the S==6 edge. Repeat with RA=0x09: Bank is unchanged.
3. Same write with nC07X=1, or with Locked=0: no BankWrP and Bank holds its prior value.
4. PHI1 glitch high for 2 C14M while LowCnt<6: no CycleStart, S keeps counting. Period 16 (long cycle): Locked stays 1 and S reaches 16→saturates at 15.
5. PHI1 stops (held low 40 C14M): S saturates at 15, Locked falls when Interval reaches 21, RefReq holds its value.
6. REF_DIV=7, 21 locked cycles: RefReq high in exactly cycles 7, 14 and 21. Assert nRES at S=4 of a bank-write cycle: all outputs zero at once and Bank=0 after release.
